// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, IF/ID register and a one-entry skid buffer
// that parks a fetched word while decode is stalled.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_id,
  output logic [31:0] npc_id,
  output logic        valid_id
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic [31:0] sk_npc_q, sk_npc_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      instr_q    <= '0;
      npc_q      <= '0;
      valid_q    <= 1'b0;
      sk_instr_q <= '0;
      sk_npc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      npc_q      <= npc_d;
      valid_q    <= valid_d;
      sk_instr_q <= sk_instr_d;
      sk_npc_q   <= sk_npc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    npc_d      = npc_q;
    valid_d    = valid_q;
    sk_instr_d = sk_instr_q;
    sk_npc_d   = sk_npc_q;
    unique case (state_q)
      RUN, HOLD: begin
        if (halt) begin
          state_d    = HALTED;
          instr_d    = '0;
          npc_d      = '0;
          valid_d    = 1'b0;
          sk_instr_d = '0;
          sk_npc_d   = '0;
        end else if (redirect) begin
          state_d    = RUN;
          pc_d       = {redirect_pc[31:2], 2'b00};
          instr_d    = '0;
          npc_d      = '0;
          valid_d    = 1'b0;
          sk_instr_d = '0;
          sk_npc_d   = '0;
        end else if (state_q == HOLD) begin
          if (!stall) begin
            state_d    = RUN;
            instr_d    = sk_instr_q;
            npc_d      = sk_npc_q;
            valid_d    = 1'b1;
            sk_instr_d = '0;
            sk_npc_d   = '0;
          end
        end else if (ihit) begin
          pc_d = pc_plus4;
          if (stall) begin
            // decode is busy: park the word so the fetch is not lost
            state_d    = HOLD;
            sk_instr_d = iload;
            sk_npc_d   = pc_plus4;
          end else begin
            instr_d = iload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!stall) begin
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign iREN     = (state_q == RUN);
  assign iaddr    = pc_q;
  assign instr_id = instr_q;
  assign npc_id   = npc_q;
  assign valid_id = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a rule-level model checked every
// cycle, plus literal expectations along each scenario.
module tb_instr_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_id;
  logic [31:0] npc_id;
  logic        valid_id;

  int checks = 0;
  int errors = 0;

  instr_fetch_stage #(.RESET_PC(32'h00000000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload), .iREN(iREN),
    .iaddr(iaddr), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .instr_id(instr_id),
    .npc_id(npc_id), .valid_id(valid_id)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a fetched word either reaches decode now or waits in `parked`
  logic        m_live;
  logic        m_dead;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_npc;
  logic        m_valid;
  logic [31:0] parked_w [$];
  logic [31:0] parked_n [$];

  always @(posedge CLK) begin
    if (RST) begin
      m_live = 1'b1; m_dead = 1'b0; m_pc = 32'h0;
      m_instr = 0; m_npc = 0; m_valid = 0;
      parked_w.delete(); parked_n.delete();
    end else if (m_live && !m_dead) begin
      if (halt || redirect) begin
        m_instr = 0; m_npc = 0; m_valid = 0;
        parked_w.delete(); parked_n.delete();
        if (halt) m_dead = 1'b1;
        else m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (parked_w.size() != 0) begin
        if (!stall) begin
          m_instr = parked_w.pop_front();
          m_npc   = parked_n.pop_front();
          m_valid = 1'b1;
        end
      end else if (ihit) begin
        if (stall) begin
          parked_w.push_back(iload);
          parked_n.push_back(m_pc + 32'd4);
        end else begin
          m_instr = iload; m_npc = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_instr = 0; m_npc = 0; m_valid = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("m_iREN", {31'b0, iREN},
          {31'b0, !m_dead && parked_w.size() == 0});
      chk("m_iaddr", iaddr, m_pc);
      chk("m_instr", instr_id, m_instr);
      chk("m_npc", npc_id, m_npc);
      chk("m_valid", {31'b0, valid_id}, {31'b0, m_valid});
    end
  end

  task automatic drive(input logic r, input logic h, input logic [31:0] w,
                       input logic s, input logic rd, input logic [31:0] rp,
                       input logic hl);
    RST = r; ihit = h; iload = w; stall = s;
    redirect = rd; redirect_pc = rp; halt = hl;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    m_live = 1'b0; m_dead = 1'b0;
    RST = 1; ihit = 0; iload = 0; stall = 0;
    redirect = 0; redirect_pc = 0; halt = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", {31'b0, valid_id}, 32'h0);
    chk("rst_iREN", {31'b0, iREN}, 32'h1);

    // straight-line fetch
    drive(0, 1, 32'h20010005, 0, 0, 0, 0);
    chk("s1_instr", instr_id, 32'h20010005);
    chk("s1_npc", npc_id, 32'h4);
    chk("s1_iaddr", iaddr, 32'h4);
    drive(0, 1, 32'h20010005, 0, 0, 0, 0);
    chk("s1_iaddr8", iaddr, 32'h8);

    // stall with a hit at PC 8 parks the word
    drive(0, 1, 32'hAAAA0008, 1, 0, 0, 0);
    chk("s2_iREN", {31'b0, iREN}, 32'h0);
    chk("s2_iaddr", iaddr, 32'hC);
    chk("s2_npc_hold", npc_id, 32'h8);
    drive(0, 1, 32'h5555_5555, 1, 0, 0, 0);
    chk("s2_still_hold", npc_id, 32'h8);
    drive(0, 1, 32'h5555_5555, 0, 0, 0, 0);
    chk("s2_instr", instr_id, 32'hAAAA0008);
    chk("s2_npc", npc_id, 32'hC);
    chk("s2_valid", {31'b0, valid_id}, 32'h1);
    chk("s2_iREN", {31'b0, iREN}, 32'h1);

    // redirect while holding flushes the parked word
    drive(0, 1, 32'hBBBB000C, 1, 0, 0, 0);
    chk("s3_hold", {31'b0, iREN}, 32'h0);
    drive(0, 1, 32'hCCCC_CCCC, 1, 1, 32'h00000041, 0);
    chk("s3_iaddr", iaddr, 32'h40);
    chk("s3_valid", {31'b0, valid_id}, 32'h0);
    chk("s3_iREN", {31'b0, iREN}, 32'h1);

    // three misses: bubbles, PC steady
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("s6_valid", {31'b0, valid_id}, 32'h0);
      chk("s6_instr", instr_id, 32'h0);
      chk("s6_iaddr", iaddr, 32'h40);
    end

    // wrap at the top of the address space
    drive(0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
    chk("s5_pc", iaddr, 32'hFFFFFFFC);
    drive(0, 1, 32'h12345678, 0, 0, 0, 0);
    chk("s5_npc", npc_id, 32'h0);
    chk("s5_iaddr", iaddr, 32'h0);
    chk("s5_instr", instr_id, 32'h12345678);

    // halt beats redirect and sticks
    drive(0, 0, 0, 0, 1, 32'h20, 0);
    drive(0, 1, 32'h1111_1111, 0, 1, 32'h100, 1);
    for (int i = 0; i < 10; i++) begin
      chk("s4_iREN", {31'b0, iREN}, 32'h0);
      chk("s4_iaddr", iaddr, 32'h20);
      chk("s4_valid", {31'b0, valid_id}, 32'h0);
      drive(0, i[0], 32'h7777_0000 + i, i[1], ~i[0], 32'h80, 1'b0);
    end

    // reset out of halted
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("r_halt_iREN", {31'b0, iREN}, 32'h1);
    chk("r_halt_iaddr", iaddr, 32'h0);

    // reset out of hold drops the parked word
    drive(0, 1, 32'h99990000, 1, 0, 0, 0);
    chk("r_hold_in", {31'b0, iREN}, 32'h0);
    drive(1, 1, 32'h0, 1, 0, 0, 0);
    drive(0, 0, 32'h0, 0, 0, 0, 0);
    chk("r_hold_iREN", {31'b0, iREN}, 32'h1);
    chk("r_hold_valid", {31'b0, valid_id}, 32'h0);
    chk("r_hold_instr", instr_id, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
